// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, frame format constant and
// the bit-time helper used to size the frame timer.
package uart_pkg;

  // 8N1 frame: start bit + 8 data bits + stop bit.
  localparam int unsigned UART_FRAME_BITS = 10;

  // Arbiter scheduling states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // System clock cycles per UART bit (integer division, truncating).
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clock cycles one frame plus its trailing idle gap occupies on the line.
  function automatic int unsigned frame_cycles(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned gap_bits);
    return bit_cycles(clk_freq, baud) * (UART_FRAME_BITS + gap_bits);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Down-counting frame timer. A load pulse presets the counter; it then
// counts down to zero and holds there. expired is high whenever the
// counter reads zero.
module uart_frame_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Counter register: load has priority over the decrement, zero is sticky.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter. One byte is granted
// from IDLE, tx_start is pulsed from LOAD, and WAIT holds off further grants
// until the frame and its trailing gap have left the line.
//
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority (req0
// always wins a tie); otherwise ties are broken round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned BIT_CYCLES   = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned FRAME_CYCLES = BIT_CYCLES * (UART_FRAME_BITS + GAP_BITS);
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES + 1);

  // WAIT starts at FRAME_CYCLES-1 and leaves on the cycle after reaching 0,
  // so WAIT lasts exactly FRAME_CYCLES cycles; with the IDLE and LOAD cycles
  // that spaces back-to-back tx_start pulses FRAME_CYCLES+2 apart.
  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(FRAME_CYCLES - 1);

  arb_state_t state;
  arb_state_t state_next;

  logic any_valid;
  logic winner;        // 0 = req0, 1 = req1
  logic grant;         // a byte is accepted at this edge
  logic timer_load;
  logic timer_expired;
  logic tx_start_next;

  assign any_valid = req0_valid | req1_valid;

`ifdef UART_ARB_FIXED_PRIO_EN

  // Fixed priority: req0 wins whenever it is valid.
  always_comb begin
    winner = req0_valid ? 1'b0 : 1'b1;
  end

`else

  // Requester favoured on the next tie; starts on req0 and flips to the
  // requester that lost each grant.
  logic rr_prio;

  // Round-robin pointer: only moves when a byte is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_prio <= 1'b0;
    end else if (grant) begin
      rr_prio <= ~winner;
    end
  end

  // Round-robin selection: tie goes to rr_prio, a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner = rr_prio;
    end else begin
      winner = req1_valid;
    end
  end

`endif

  // Next-state and strobe decode for the IDLE/LOAD/WAIT sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next    = state;
    grant         = 1'b0;
    timer_load    = 1'b0;
    tx_start_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          grant      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        timer_load    = 1'b1;
        tx_start_next = 1'b1;
        state_next    = WAIT;
      end
      WAIT: begin
        if (timer_expired) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= tx_start_next;
      req0_ack <= grant & ~winner;
      req1_ack <= grant &  winner;
      // busy covers the granting IDLE cycle as well as LOAD and WAIT,
      // registered so it is glitch-free toward the requesters.
      busy     <= (state != IDLE) | grant;
      if (grant) begin
        tx_data  <= winner ? req1_data : req0_data;
        grant_id <= winner;
      end
    end
  end

  uart_frame_timer #(
    .WIDTH (CNT_W)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (LOAD_VALUE),
    .expired    (timer_expired)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with CLK_FREQ=1000, BAUD=100,
// GAP_BITS=1 (FRAME_CYCLES=110). Expected bytes are queued when a request is
// driven and popped by the tx_start monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned GAP_BITS = 1;
  localparam int          SPACING  = 112;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ack;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ack;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       grant_id;

  uart_tx_arbiter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ack   (req1_ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       eid;
    logic [7:0] edata;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   ack0_count = 0;
  int   ack1_count = 0;
  int   start_count = 0;
  exp_t exp_q[$];
  int   start_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_req0_ack"}, 32'(req0_ack), 32'd0);
    check({tag, "_req1_ack"}, 32'(req1_ack), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  // Monitor: one-hot acks, and every tx_start matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (req0_ack === 1'b1 || req1_ack === 1'b1)
        check("ack_onehot", 32'(req0_ack & req1_ack), 32'd0);
      if (req0_ack === 1'b1) ack0_count++;
      if (req1_ack === 1'b1) ack1_count++;
      if (tx_start === 1'b1) begin
        start_count++;
        start_cycles.push_back(cycle);
        check("tx_start_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_tx_data", 32'(tx_data), 32'(e.data));
          check("sb_grant_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   base;
    int   s0;
    int   a1;
    int   sc_base;
    int   n;

`ifdef UART_ARB_FIXED_PRIO_EN
    vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h33};
    vecs[2] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 8'h44};
    vecs[3] = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 8'h66};
    vecs[4] = '{1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 8'h77};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h99};
`else
    // Pointer favours req1 after the opening single req0 grant.
    vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h33};
    vecs[2] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 8'h44};
    vecs[3] = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 8'h66};
    vecs[4] = '{1'b1, 8'h77, 1'b1, 8'h88, 1'b1, 8'h88};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h99};
`endif

    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single request: ack at 1, tx_start at 2, busy falls at 113.
    base = cycle;
    req0_valid = 1'b1;
    req0_data  = 8'h31;
    exp_q.push_back('{1'b0, 8'h31});
    step();
    check("single_ack0", 32'(req0_ack), 32'd1);
    check("single_ack1", 32'(req1_ack), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    req0_valid = 1'b0;
    step();
    check("single_tx_start", 32'(tx_start), 32'd1);
    check("single_start_cycle", 32'(cycle - base), 32'd2);
    while (cycle - base < 112) step();
    check("single_busy_112", 32'(busy), 32'd1);
    step();
    check("single_busy_113", 32'(busy), 32'd0);
    check("single_data_held", 32'(tx_data), 32'h31);

    // Table-driven grants from IDLE.
    for (int i = 0; i < 6; i++) begin
      req0_valid = vecs[i].v0;
      req0_data  = vecs[i].d0;
      req1_valid = vecs[i].v1;
      req1_data  = vecs[i].d1;
      exp_q.push_back('{vecs[i].eid, vecs[i].edata});
      step();
      check($sformatf("vec%0d_ack0", i), 32'(req0_ack), 32'(!vecs[i].eid));
      check($sformatf("vec%0d_ack1", i), 32'(req1_ack), 32'(vecs[i].eid));
      check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].eid));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      check($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'd1);
      wait_idle();
    end

    // Continuous tie: four frames, fixed spacing.
    s0      = start_count;
    a1      = ack1_count;
    sc_base = start_cycles.size();
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b0, 8'hA0});
`else
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b1, 8'hB1});
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b1, 8'hB1});
`endif
    req0_valid = 1'b1;
    req0_data  = 8'hA0;
    req1_valid = 1'b1;
    req1_data  = 8'hB1;
    n = 0;
    while (start_count < s0 + 4 && n < 600) begin
      step();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_timeout", 32'(n < 600), 32'd1);
    if (start_cycles.size() >= sc_base + 4) begin
      for (int k = 1; k < 4; k++)
        check($sformatf("tie_spacing%0d", k),
              32'(start_cycles[sc_base + k] - start_cycles[sc_base + k - 1]), 32'(SPACING));
    end
`ifdef UART_ARB_FIXED_PRIO_EN
    check("tie_req1_acks", 32'(ack1_count - a1), 32'd0);
`else
    check("tie_req1_acks", 32'(ack1_count - a1), 32'd2);
`endif
    wait_idle();

    // Arrival during WAIT: req1 granted only after the return to IDLE.
    base = cycle;
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    exp_q.push_back('{1'b0, 8'hC3});
    step();
    req0_valid = 1'b0;
    step();
    while (cycle - base < 50) step();
    req1_valid = 1'b1;
    req1_data  = 8'hB1;
    exp_q.push_back('{1'b1, 8'hB1});
    n = 0;
    while (req1_ack !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("arrival_ack_cycle", 32'(cycle - base), 32'd113);
    req1_valid = 1'b0;
    step();
    check("arrival_tx_start", 32'(tx_start), 32'd1);
    check("arrival_tx_data", 32'(tx_data), 32'hB1);
    wait_idle();

    // Withdrawn request: a 3-cycle req1 pulse during WAIT is ignored.
    s0 = start_count;
    a1 = ack1_count;
    base = cycle;
    req0_valid = 1'b1;
    req0_data  = 8'hD4;
    exp_q.push_back('{1'b0, 8'hD4});
    step();
    req0_valid = 1'b0;
    step();
    while (cycle - base < 30) step();
    req1_valid = 1'b1;
    req1_data  = 8'h77;
    repeat (3) step();
    req1_valid = 1'b0;
    wait_idle();
    repeat (5) step();
    check("withdrawn_starts", 32'(start_count - s0), 32'd1);
    check("withdrawn_req1_acks", 32'(ack1_count - a1), 32'd0);

    // Reset in WAIT aborts the frame; a new request then starts normally.
    base = cycle;
    req0_valid = 1'b1;
    req0_data  = 8'hE5;
    exp_q.push_back('{1'b0, 8'hE5});
    step();
    req0_valid = 1'b0;
    step();
    while (cycle - base < 42) step();
    rst = 1'b1;
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    s0 = start_count;
    repeat (3) step();
    check("midreset_no_start", 32'(start_count - s0), 32'd0);
    base = cycle;
    req0_valid = 1'b1;
    req0_data  = 8'hF6;
    exp_q.push_back('{1'b0, 8'hF6});
    step();
    check("post_reset_ack0", 32'(req0_ack), 32'd1);
    req0_valid = 1'b0;
    step();
    check("post_reset_tx_start", 32'(tx_start), 32'd1);
    check("post_reset_start_cycle", 32'(cycle - base), 32'd2);
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
